// File: rtl/hv_rotator_pkg.sv
// Shared types and elaboration helpers for the pipelined hypervector rotator.
package hv_rotator_pkg;

  typedef enum logic {
    ROT_RIGHT = 1'b0,
    ROT_LEFT  = 1'b1
  } rot_dir_e;

  function automatic int unsigned num_stages(input int unsigned shift_size,
                                             input int unsigned levels);
    return (shift_size + levels - 1) / levels;
  endfunction

endpackage

// File: rtl/hv_rotator_slice.sv
// One pipeline slice: a group of log-shifter rotate levels followed by a
// valid/ready register stage that carries data, remaining shift, dir and tag.
module hv_rotator_slice
  import hv_rotator_pkg::*;
#(
  parameter int unsigned HV_LENGTH   = 512,
  parameter int unsigned SHIFT_SIZE  = 9,
  parameter int unsigned FIRST_LEVEL = 0,
  parameter int unsigned NUM_LEVELS  = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [HV_LENGTH-1:0]  data_i,
  input  logic [SHIFT_SIZE-1:0] shift_i,
  input  logic                  dir_i,
  input  logic [TAG_W-1:0]      tag_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [HV_LENGTH-1:0]  data_o,
  output logic [SHIFT_SIZE-1:0] shift_o,
  output logic                  dir_o,
  output logic [TAG_W-1:0]      tag_o
);

  localparam logic [63:0] MASK64 = ((64'd1 << NUM_LEVELS) - 64'd1) << FIRST_LEVEL;
  localparam logic [SHIFT_SIZE-1:0] LEVEL_MASK = MASK64[SHIFT_SIZE-1:0];

  logic [NUM_LEVELS:0][HV_LENGTH-1:0] w_lvl;
  logic                               w_left;
  logic [SHIFT_SIZE-1:0]              w_shift_rem;

  logic                  r_valid;
  logic [HV_LENGTH-1:0]  r_data;
  logic [SHIFT_SIZE-1:0] r_shift;
  rot_dir_e              r_dir;
  logic [TAG_W-1:0]      r_tag;

  assign w_left      = (rot_dir_e'(dir_i) == ROT_LEFT);
  assign w_lvl[0]    = data_i;
  // Bits consumed here are cleared so later slices only see what remains.
  assign w_shift_rem = shift_i & ~LEVEL_MASK;

  for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_level
    localparam int unsigned K   = FIRST_LEVEL + l;
    localparam int unsigned AMT = (32'd1 << K) % HV_LENGTH;
    logic [HV_LENGTH-1:0] w_rot;

    if (AMT == 0) begin : g_ident
      assign w_rot = w_lvl[l];
    end else begin : g_rot
      logic [HV_LENGTH-1:0] w_src;
      assign w_src = w_lvl[l];
      assign w_rot = w_left
                   ? {w_src[HV_LENGTH-AMT-1:0], w_src[HV_LENGTH-1:HV_LENGTH-AMT]}
                   : {w_src[AMT-1:0], w_src[HV_LENGTH-1:AMT]};
    end

    assign w_lvl[l+1] = shift_i[K] ? w_rot : w_lvl[l];
  end

  assign ready_o = !r_valid || ready_i;

  // Flush clears only the valid bit; payload registers keep their contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_shift <= '0;
      r_dir   <= ROT_RIGHT;
      r_tag   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (ready_o) begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_data  <= w_lvl[NUM_LEVELS];
        r_shift <= w_shift_rem;
        r_dir   <= rot_dir_e'(dir_i);
        r_tag   <= tag_i;
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign shift_o = r_shift;
  assign dir_o   = r_dir;
  assign tag_o   = r_tag;

endmodule

// File: rtl/hv_rotator_pipelined.sv
// Pipelined HDC permutation unit: rotates a hypervector left/right by a
// per-item amount, with mux levels grouped into valid/ready register slices.
module hv_rotator_pipelined
  import hv_rotator_pkg::*;
#(
  parameter int unsigned HV_LENGTH        = 512,
  parameter int unsigned SHIFT_SIZE       = $clog2(HV_LENGTH),
  parameter int unsigned LEVELS_PER_STAGE = 2,
  parameter int unsigned TAG_W            = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [HV_LENGTH-1:0]  in_data_i,
  input  logic [SHIFT_SIZE-1:0] in_shift_i,
  input  logic                  in_dir_i,
  input  logic [TAG_W-1:0]      in_tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [HV_LENGTH-1:0]  out_data_o,
  output logic [TAG_W-1:0]      out_tag_o,
  output logic                  busy_o
);

  localparam int unsigned NUM_STAGES = num_stages(SHIFT_SIZE, LEVELS_PER_STAGE);

  if (HV_LENGTH < 2) begin : g_bad_length
    $error("HV_LENGTH must be at least 2");
  end
  if (LEVELS_PER_STAGE < 1 || LEVELS_PER_STAGE > SHIFT_SIZE) begin : g_bad_levels
    $error("LEVELS_PER_STAGE must lie in 1..SHIFT_SIZE");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("TAG_W must be at least 1");
  end

  logic [NUM_STAGES:0]                 w_valid;
  logic [NUM_STAGES:0]                 w_ready;
  logic [NUM_STAGES:0][HV_LENGTH-1:0]  w_data;
  logic [NUM_STAGES:0][SHIFT_SIZE-1:0] w_shift;
  logic [NUM_STAGES:0]                 w_dir;
  logic [NUM_STAGES:0][TAG_W-1:0]      w_tag;
  logic                                w_tail_unused;

  assign w_valid[0]          = in_valid_i;
  assign w_data[0]           = in_data_i;
  assign w_shift[0]          = in_shift_i;
  assign w_dir[0]            = in_dir_i;
  assign w_tag[0]            = in_tag_i;
  assign w_ready[NUM_STAGES] = out_ready_i;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int unsigned FIRST = s * LEVELS_PER_STAGE;
    localparam int unsigned NUM   = (SHIFT_SIZE - FIRST < LEVELS_PER_STAGE)
                                  ? (SHIFT_SIZE - FIRST) : LEVELS_PER_STAGE;

    hv_rotator_slice #(
      .HV_LENGTH  (HV_LENGTH),
      .SHIFT_SIZE (SHIFT_SIZE),
      .FIRST_LEVEL(FIRST),
      .NUM_LEVELS (NUM),
      .TAG_W      (TAG_W)
    ) u_slice (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush_i(flush_i),
      .valid_i(w_valid[s]),
      .ready_o(w_ready[s]),
      .data_i (w_data[s]),
      .shift_i(w_shift[s]),
      .dir_i  (w_dir[s]),
      .tag_i  (w_tag[s]),
      .valid_o(w_valid[s+1]),
      .ready_i(w_ready[s+1]),
      .data_o (w_data[s+1]),
      .shift_o(w_shift[s+1]),
      .dir_o  (w_dir[s+1]),
      .tag_o  (w_tag[s+1])
    );
  end

  // The last slice's leftover shift and dir have no consumer.
  assign w_tail_unused = ^{w_shift[NUM_STAGES], w_dir[NUM_STAGES]};

  // A flushing pipe accepts (and drops) whatever is offered.
  assign in_ready_o  = w_ready[0] | flush_i;
  assign out_valid_o = w_valid[NUM_STAGES];
  assign out_data_o  = w_data[NUM_STAGES];
  assign out_tag_o   = w_tag[NUM_STAGES];
  assign busy_o      = |w_valid[NUM_STAGES:1];

endmodule

// File: tb/tb_hv_rotator_pipelined.sv
// Directed and randomised checks of hv_rotator_pipelined at 64 and 48 bits.
module tb_hv_rotator_pipelined;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 64-bit instance
  logic        flush, in_valid, in_ready, in_dir, out_valid, out_ready, busy;
  logic [63:0] in_data, out_data;
  logic [5:0]  in_shift;
  logic [3:0]  in_tag, out_tag;

  // 48-bit instance
  logic        b_flush, b_in_valid, b_in_ready, b_in_dir, b_out_valid, b_out_ready, b_busy;
  logic [47:0] b_in_data, b_out_data;
  logic [5:0]  b_in_shift;
  logic [3:0]  b_in_tag, b_out_tag;

  hv_rotator_pipelined #(.HV_LENGTH(64), .LEVELS_PER_STAGE(2), .TAG_W(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_shift_i(in_shift), .in_dir_i(in_dir), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_tag_o(out_tag), .busy_o(busy)
  );

  hv_rotator_pipelined #(.HV_LENGTH(48), .LEVELS_PER_STAGE(2), .TAG_W(4)) u_dut48 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .in_shift_i(b_in_shift), .in_dir_i(b_in_dir), .in_tag_i(b_in_tag),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_tag_o(b_out_tag), .busy_o(b_busy)
  );

  function automatic logic [63:0] ref_rot64(input logic [63:0] d, input int unsigned s,
                                            input logic left);
    int unsigned a;
    a = s % 64;
    if (left) return (d << a) | (d >> (64 - a));
    return (d >> a) | (d << (64 - a));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0;
    in_dir = 1'b0; in_tag = '0; out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_shift = '0;
    b_in_dir = 1'b0; b_in_tag = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready48 got=%b want=1", b_in_ready); end
  endtask

  task automatic test_rotate64();
    logic [63:0] v_data [8];
    logic [63:0] v_exp  [8];
    logic [5:0]  v_shift[8];
    logic        v_dir  [8];
    int lat;
    v_data[0] = 64'h1; v_shift[0] = 6'd1;  v_dir[0] = 1'b0; v_exp[0] = 64'h8000_0000_0000_0000;
    v_data[1] = 64'h1; v_shift[1] = 6'd1;  v_dir[1] = 1'b1; v_exp[1] = 64'h2;
    v_data[2] = 64'h1; v_shift[2] = 6'd0;  v_dir[2] = 1'b0; v_exp[2] = 64'h1;
    v_data[3] = 64'h1; v_shift[3] = 6'd0;  v_dir[3] = 1'b1; v_exp[3] = 64'h1;
    v_data[4] = 64'h0123_4567_89AB_CDEF; v_shift[4] = 6'd16; v_dir[4] = 1'b1; v_exp[4] = 64'h4567_89AB_CDEF_0123;
    v_data[5] = 64'h0123_4567_89AB_CDEF; v_shift[5] = 6'd16; v_dir[5] = 1'b0; v_exp[5] = 64'hCDEF_0123_4567_89AB;
    v_data[6] = 64'h1; v_shift[6] = 6'd63; v_dir[6] = 1'b1; v_exp[6] = 64'h8000_0000_0000_0000;
    v_data[7] = 64'h0123_4567_89AB_CDEF; v_shift[7] = 6'd4; v_dir[7] = 1'b0; v_exp[7] = 64'hF012_3456_789A_BCDE;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_data = v_data[k]; in_shift = v_shift[k]; in_dir = v_dir[k]; in_tag = 4'(k);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rot_in_ready[%0d] got=%b want=1", k, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++; if (lat != 3) begin errors++; $display("FAIL rot_latency[%0d] got=%0d want=3", k, lat); end
      checks++; if (out_data !== v_exp[k]) begin errors++; $display("FAIL rot_data[%0d] got=%h want=%h", k, out_data, v_exp[k]); end
      checks++; if (out_tag !== 4'(k)) begin errors++; $display("FAIL rot_tag[%0d] got=%h want=%h", k, out_tag, 4'(k)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap48();
    logic [47:0] v_exp  [4];
    logic [5:0]  v_shift[4];
    logic        v_dir  [4];
    int lat;
    v_shift[0] = 6'd47; v_dir[0] = 1'b0; v_exp[0] = 48'h2;
    v_shift[1] = 6'd63; v_dir[1] = 1'b1; v_exp[1] = 48'h8000;
    v_shift[2] = 6'd48; v_dir[2] = 1'b0; v_exp[2] = 48'h1;
    v_shift[3] = 6'd0;  v_dir[3] = 1'b1; v_exp[3] = 48'h1;
    b_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_in_valid = 1'b1; b_in_data = 48'h1; b_in_shift = v_shift[k]; b_in_dir = v_dir[k]; b_in_tag = 4'(k + 8);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      lat = 1;
      while (b_out_valid !== 1'b1 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++; if (lat != 3) begin errors++; $display("FAIL wrap48_latency[%0d] got=%0d want=3", k, lat); end
      checks++; if (b_out_data !== v_exp[k]) begin errors++; $display("FAIL wrap48_data[%0d] got=%h want=%h", k, b_out_data, v_exp[k]); end
      checks++; if (b_out_tag !== 4'(k + 8)) begin errors++; $display("FAIL wrap48_tag[%0d] got=%h want=%h", k, b_out_tag, 4'(k + 8)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] bp_d[5], bp_exp[5];
    logic [5:0]  bp_s[5];
    logic        bp_dir[5];
    logic [63:0] d, held_d;
    logic [3:0]  t, held_t;
    logic        hs_in, hs_out, held;
    int idx, exp_tag, last_cyc;
    bit extra;
    for (int k = 0; k < 5; k++) begin
      bp_d[k]   = 64'h0123_4567_89AB_CDEF ^ {16{4'(k)}};
      bp_s[k]   = 6'(k * 13 + 1);
      bp_dir[k] = (k % 2) == 1;
      bp_exp[k] = ref_rot64(bp_d[k], bp_s[k], bp_dir[k]);
    end
    out_ready = 1'b0; idx = 0; exp_tag = 0; last_cyc = 0; held = 1'b0;
    held_d = '0; held_t = '0;
    for (int cyc = 0; cyc < 40 && exp_tag < 5; cyc++) begin
      in_valid = (idx < 5);
      if (idx < 5) begin
        in_data = bp_d[idx]; in_shift = bp_s[idx]; in_dir = bp_dir[idx]; in_tag = 4'(idx);
      end
      if (cyc == 6) begin
        checks++; if (idx != 3) begin errors++; $display("FAIL bp_accepted got=%0d want=3", idx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got=%b want=0", in_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got=%b want=1", busy); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL bp_head_tag got=%h want=0", out_tag); end
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && !out_ready) begin
        if (held) begin
          checks++;
          if (out_data !== held_d || out_tag !== held_t) begin
            errors++; $display("FAIL bp_stall_stable got=%h/%h want=%h/%h", out_data, out_tag, held_d, held_t);
          end
        end else begin
          held = 1'b1; held_d = out_data; held_t = out_tag;
        end
      end
      hs_in = in_valid && in_ready; hs_out = out_valid && out_ready;
      d = out_data; t = out_tag;
      @(posedge clk); #1;
      if (hs_in) idx++;
      if (hs_out) begin
        checks++; if (t !== 4'(exp_tag)) begin errors++; $display("FAIL bp_order got=%h want=%h", t, 4'(exp_tag)); end
        checks++; if (d !== bp_exp[exp_tag]) begin errors++; $display("FAIL bp_data[%0d] got=%h want=%h", exp_tag, d, bp_exp[exp_tag]); end
        if (exp_tag > 0) begin
          checks++; if (cyc != last_cyc + 1) begin errors++; $display("FAIL bp_rate got_gap=%0d want=1", cyc - last_cyc); end
        end
        last_cyc = cyc;
        exp_tag++;
      end
    end
    in_valid = 1'b0;
    checks++; if (exp_tag != 5) begin errors++; $display("FAIL bp_drain got=%0d want=5 items", exp_tag); end
    extra = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) extra = 1'b1;
    end
    checks++; if (extra) begin errors++; $display("FAIL bp_duplicate got=extra_output want=none"); end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 64'hA5A5_0000_0000_0000 | 64'(k); in_shift = 6'd3; in_dir = 1'b1; in_tag = 4'(k + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got=%b want=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rstmid_data got=%h want=0", out_data); end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_ghost got=output want=none"); end
  endtask

  task automatic test_flush();
    logic [63:0] held_d;
    bit seen;
    int lat;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 64'hFEED_0000_0000_0000 | 64'(k); in_shift = 6'd8; in_dir = 1'b0; in_tag = 4'(k + 4);
      @(posedge clk); #1;
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full got=%b want=0", in_ready); end
    flush = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001; in_tag = 4'hF;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
    held_d = out_data;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b want=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== held_d) begin errors++; $display("FAIL flush_data_kept got=%h want=%h", out_data, held_d); end
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL flush_ghost got=output want=none"); end
    in_valid = 1'b1; in_data = 64'h1; in_shift = 6'd1; in_dir = 1'b0; in_tag = 4'h9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (out_data !== 64'h8000_0000_0000_0000 || out_tag !== 4'h9) begin
      errors++; $display("FAIL flush_recover got=%h/%h want=8000000000000000/9", out_data, out_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [63:0] q_d[$];
    logic [3:0]  q_t[$];
    logic [63:0] d, ed;
    logic [3:0]  t, et;
    logic        hs_in, hs_out;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0;
    in_valid = 1'b0;
    while (recv < 10000 && cyc < 60000) begin
      if (!in_valid && sent < 10000 && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        in_data  = {$urandom(), $urandom()};
        in_shift = 6'($urandom_range(63));
        in_dir   = 1'($urandom_range(1));
        in_tag   = 4'(sent);
      end
      out_ready = ($urandom_range(9) < 7);
      #1;
      hs_in = in_valid && in_ready; hs_out = out_valid && out_ready;
      d = out_data; t = out_tag;
      if (hs_in) begin
        q_d.push_back(ref_rot64(in_data, in_shift, in_dir));
        q_t.push_back(in_tag);
      end
      @(posedge clk); #1;
      cyc++;
      if (hs_in) begin
        sent++;
        in_valid = 1'b0;
      end
      if (hs_out) begin
        checks++;
        if (q_d.size() == 0) begin
          errors++; $display("FAIL rand_unexpected got=%h/%h want=no_output", d, t);
        end else begin
          ed = q_d.pop_front(); et = q_t.pop_front();
          if (d !== ed || t !== et) begin
            errors++; $display("FAIL rand_item[%0d] got=%h/%h want=%h/%h", recv, d, t, ed, et);
          end
        end
        recv++;
      end
    end
    in_valid = 1'b0;
    checks++; if (recv != 10000) begin errors++; $display("FAIL rand_count got=%0d want=10000", recv); end
    checks++; if (q_d.size() != 0) begin errors++; $display("FAIL rand_leftover got=%0d want=0", q_d.size()); end
  endtask

  initial begin
    test_reset();
    test_rotate64();
    test_wrap48();
    test_back_to_back();
    test_reset_midflight();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
